// File: rtl/load_store_unit_if.sv
// Bundles the datapath-facing request/response signals and the data-memory
// port of the load/store unit. The slave side is the LSU itself. The master
// side is the surrounding datapath plus the memory that returns dm_readdata.
interface load_store_unit_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic [31:0] bad_vaddr;
    logic        dm_memwrite;
    logic [31:0] dm_endereco;
    logic [31:0] dm_writedata;
    logic [31:0] dm_readdata;

    modport master (
        output mem_read,
        output mem_write,
        output size,
        output load_unsigned,
        output addr,
        output wdata,
        output dm_readdata,
        input  rdata,
        input  stall,
        input  misaligned,
        input  bad_vaddr,
        input  dm_memwrite,
        input  dm_endereco,
        input  dm_writedata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  size,
        input  load_unsigned,
        input  addr,
        input  wdata,
        input  dm_readdata,
        output rdata,
        output stall,
        output misaligned,
        output bad_vaddr,
        output dm_memwrite,
        output dm_endereco,
        output dm_writedata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed loads/stores into word accesses on a
// word-addressed data memory. Sub-word loads are extracted and extended
// combinationally. Sub-word stores use a two-cycle read-modify-write through
// merge_reg. Misaligned accesses are suppressed and their address is latched.
module load_store_unit (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] merge_reg;
    logic [31:0] merge_next;
    logic [31:0] bad_vaddr_reg;

    // Access decode
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        request;
    logic        misaligned_raw;

    // size 2'b11 falls into the word case along with 2'b10.
    assign is_byte        = (bus.size == 2'b00);
    assign is_half        = (bus.size == 2'b01);
    assign is_word        = bus.size[1];
    assign request        = bus.mem_read | bus.mem_write;
    assign misaligned_raw = (is_half & bus.addr[0]) |
                            (is_word & (bus.addr[1:0] != 2'b00));

    // Lane views of the memory word (little-endian: byte k = bits [8k+7:8k])
    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [31:0] merged_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = bus.dm_readdata[8*gi +: 8];
        end

        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = bus.dm_readdata[16*gi +: 16];
        end

        // Per-lane store merge. A byte store replaces exactly one lane.
        // A halfword store replaces the lane pair chosen by addr[1].
        for (gi = 0; gi < 4; gi++) begin : g_merge_lane
            assign merged_word[8*gi +: 8] =
                (is_byte && (bus.addr[1:0] == 2'(gi))) ? bus.wdata[7:0] :
                (is_half && (bus.addr[1]   == 1'(gi / 2))) ? bus.wdata[8*(gi % 2) +: 8] :
                byte_lane[gi];
        end
    endgenerate

    // Select and extend the load result from the addressed lane.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;

    // Build the extended load value for the current size and signedness.
    always_comb begin
        sel_byte   = byte_lane[bus.addr[1:0]];
        sel_half   = half_lane[bus.addr[1]];
        load_value = bus.dm_readdata;
        if (is_byte) begin
            load_value = bus.load_unsigned ? {24'b0, sel_byte}
                                           : {{24{sel_byte[7]}}, sel_byte};
        end else if (is_half) begin
            load_value = bus.load_unsigned ? {16'b0, sel_half}
                                           : {{16{sel_half[15]}}, sel_half};
        end
    end

    // Raw (pre-reset-gating) combinational outputs.
    logic        stall_c;
    logic        memwrite_c;
    logic [31:0] writedata_c;
    logic [31:0] rdata_c;

    // Next-state and output logic. In MERGE the held instruction is not
    // re-decoded; the merged word is simply written back.
    always_comb begin
        state_next  = state_reg;
        merge_next  = merge_reg;
        stall_c     = 1'b0;
        memwrite_c  = 1'b0;
        writedata_c = bus.wdata;
        rdata_c     = 32'b0;
        case (state_reg)
            IDLE: begin
                if (request && !misaligned_raw) begin
                    if (bus.mem_write) begin
                        // A store wins when mem_read is also set; rdata stays 0.
                        if (is_word) begin
                            memwrite_c  = 1'b1;
                            writedata_c = bus.wdata;
                        end else begin
                            stall_c    = 1'b1;
                            merge_next = merged_word;
                            state_next = MERGE;
                        end
                    end else begin
                        rdata_c = load_value;
                    end
                end
            end
            MERGE: begin
                memwrite_c  = 1'b1;
                writedata_c = merge_reg;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and merge buffer. An asserted reset drops a pending RMW.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            merge_reg <= 32'b0;
        end else begin
            state_reg <= state_next;
            merge_reg <= merge_next;
        end
    end

    // Capture the address of a suppressed misaligned request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_vaddr_reg <= 32'b0;
        end else if (state_reg == IDLE && request && misaligned_raw) begin
            bad_vaddr_reg <= bus.addr;
        end
    end

    // While reset is high, the control-like outputs are held at 0.
    // This keeps a write from reaching memory in an aborted RMW.
    assign bus.stall        = stall_c & ~reset;
    assign bus.dm_memwrite  = memwrite_c & ~reset;
    assign bus.misaligned   = request & misaligned_raw & ~reset;
    assign bus.rdata        = reset ? 32'b0 : rdata_c;
    assign bus.dm_writedata = writedata_c;
    assign bus.dm_endereco  = {2'b00, bus.addr[31:2]};
    assign bus.bad_vaddr    = bad_vaddr_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// randomized loads/stores checked against a word-array reference model.
module tb_load_store_unit;

    logic clk;
    logic reset;
    logic clear_mem;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory seen by the DUT: combinational read, write at rising edge.
    logic [31:0] mem [256];
    assign bus.dm_readdata = mem[bus.dm_endereco[7:0]];

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'b0;
        end else if (bus.dm_memwrite) begin
            mem[bus.dm_endereco[7:0]] <= bus.dm_writedata;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    logic [31:0] ref_bad;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
        logic [31:0] w;
        int          off;
        longint      v;
        w   = ref_mem[a[9:2]];
        off = int'(a % 4);
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = (w >> (8 * off)) % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w;
        logic [31:0] mask;
        int          off;
        w    = ref_mem[a[9:2]];
        off  = int'(a % 4);
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    endfunction

    task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.size          = sz;
        bus.load_unsigned = uns;
        bus.addr          = a;
        bus.wdata         = wd;
    endtask

    // One complete transaction, checked cycle by cycle against the model.
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd);
        bit          mis;
        logic [31:0] exp_word;
        logic [31:0] seen_rdata;
        @(negedge clk);
        drive(rd, wr, sz, uns, a, wd);
        #1;
        seen_rdata = bus.rdata;
        check_eq("endereco", bus.dm_endereco, a >> 2);
        check_eq("bad_vaddr_hold", bus.bad_vaddr, ref_bad);
        mis = ref_misaligned(sz, a);
        if (!rd && !wr) begin
            check_eq("idle_rdata", bus.rdata, 32'h0);
            check_eq("idle_stall", 32'(bus.stall), 32'h0);
            check_eq("idle_wr", 32'(bus.dm_memwrite), 32'h0);
        end else if (mis) begin
            check_eq("mis_flag", 32'(bus.misaligned), 32'h1);
            check_eq("mis_stall", 32'(bus.stall), 32'h0);
            check_eq("mis_wr", 32'(bus.dm_memwrite), 32'h0);
            check_eq("mis_rdata", bus.rdata, 32'h0);
            @(posedge clk);
            #1;
            ref_bad = a;
            check_eq("bad_vaddr", bus.bad_vaddr, ref_bad);
        end else begin
            check_eq("mis_flag0", 32'(bus.misaligned), 32'h0);
            if (wr) begin
                check_eq("st_rdata", bus.rdata, 32'h0);
                if (sz[1]) begin
                    check_eq("sw_wr", 32'(bus.dm_memwrite), 32'h1);
                    check_eq("sw_stall", 32'(bus.stall), 32'h0);
                    check_eq("sw_data", bus.dm_writedata, wd);
                    @(posedge clk);
                    ref_mem[a[9:2]] = wd;
                end else begin
                    check_eq("rmw1_stall", 32'(bus.stall), 32'h1);
                    check_eq("rmw1_wr", 32'(bus.dm_memwrite), 32'h0);
                    exp_word = ref_merge(sz, a, wd);
                    @(negedge clk);
                    #1;
                    check_eq("rmw2_stall", 32'(bus.stall), 32'h0);
                    check_eq("rmw2_wr", 32'(bus.dm_memwrite), 32'h1);
                    check_eq("rmw2_data", bus.dm_writedata, exp_word);
                    @(posedge clk);
                    ref_mem[a[9:2]] = exp_word;
                end
            end else begin
                check_eq("ld_rdata", bus.rdata, ref_load(sz, uns, a));
                check_eq("ld_stall", 32'(bus.stall), 32'h0);
                check_eq("ld_wr", 32'(bus.dm_memwrite), 32'h0);
            end
        end
        $display("txn rd=%0d wr=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h mis=%0d",
                 rd, wr, sz, uns, a, wd, seen_rdata, mis);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'b0;
        ref_bad   = 32'b0;
        reset     = 1'b1;
        clear_mem = 1'b1;
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h13, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_stall", 32'(bus.stall), 32'h0);
        check_eq("rst_wr", 32'(bus.dm_memwrite), 32'h0);
        check_eq("rst_mis", 32'(bus.misaligned), 32'h0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_bad", bus.bad_vaddr, 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        clear_mem = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

        // Directed walkthrough
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF); // SW
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);        // LW
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA); // SB
        check_eq("sb_word", ref_mem[4], 32'hDEADAAEF);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);        // LB
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);        // LBU
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234); // SH
        check_eq("sh_word", ref_mem[4], 32'h1234AAEF);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);        // LH
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);        // LH
        access(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);        // LHU
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);        // LW misaligned
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h5678);     // SH misaligned

        // Reset asserted during the MERGE cycle of an SB
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h55);
        #1;
        check_eq("abort_c1_stall", 32'(bus.stall), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("abort_wr", 32'(bus.dm_memwrite), 32'h0);
        check_eq("abort_stall", 32'(bus.stall), 32'h0);
        check_eq("abort_rdata", bus.rdata, 32'h0);
        check_eq("abort_mis", 32'(bus.misaligned), 32'h0);
        @(posedge clk);
        #1;
        check_eq("abort_wr_edge", 32'(bus.dm_memwrite), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        ref_bad = 32'h0;
        $display("txn reset during merge addr=00000010");
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);        // word unchanged
        check_eq("abort_word", ref_mem[4], 32'h1234AAEF);

        // Back-to-back sub-word stores on a zeroed word
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h11);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h22);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check_eq("b2b_word", ref_mem[8], 32'h00002211);

        // Randomized traffic over a small window so RMWs overlap loads.
        for (int t = 0; t < 300; t++) begin
            int          op;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [31:0] wd;
            bit          uns;
            op  = int'($urandom_range(0, 8));
            sz  = 2'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, 63));
            wd  = $urandom;
            uns = 1'($urandom_range(0, 1));
            if (op <= 4)      access(1'b1, 1'b0, sz, uns, a, wd);
            else if (op <= 6) access(1'b0, 1'b1, sz, uns, a, wd);
            else if (op == 7) access(1'b1, 1'b1, sz, uns, a, wd);
            else              access(1'b0, 1'b0, sz, uns, a, wd);
        end

        // Final sweep comparing the DUT's memory against the model.
        for (int w = 0; w < 16; w++) begin
            access(1'b1, 1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the datapath (ALU result, rt operand, control) and the word-addressed data memory. Converts byte-address loads and stores into word accesses. Performs byte/halfword extraction with sign or zero extension on loads, and a two-cycle read-modify-write for byte/halfword stores. Detects misaligned accesses, suppresses them, and records the faulting address.

## Interface
- No parameters; memory word index is fixed at 8 bits (256 words).
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- mem_read  in  1  load request from control.
- mem_write  in  1  store request from control.
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- load_unsigned  in  1  1 = zero-extend sub-word loads (LBU/LHU).
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rt); only the low byte or halfword is used for sub-word stores.
- rdata  out  32  extended load result to writeback.
- stall  out  1  1 = hold PC and pipeline inputs this cycle.
- misaligned  out  1  combinational flag for the current access.
- bad_vaddr  out  32  registered address of the last misaligned access.
- dm_memwrite  out  1  to data memory write enable.
- dm_endereco  out  32  word index to memory, always {2'b00, addr[31:2]}.
- dm_writedata  out  32  word to memory.
- dm_readdata  in  32  combinational read word from memory.

## Operation
- Little-endian: byte k of a word = bits [8k+7:8k], selected by addr[1:0]; halfword selected by addr[1].
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. When misaligned=1 and mem_read or mem_write is set:
  - no write, no stall, rdata=0;
  - bad_vaddr <= addr at the next edge.
- Loads (IDLE, aligned):
  - rdata = selected byte/half/word from dm_readdata, sign-extended unless load_unsigned;
  - zero latency, no stall.
- Word store (IDLE, aligned): dm_memwrite=1, dm_writedata=wdata in the same cycle, no stall.
- Sub-word store, two states:
  - IDLE: sub-word store seen. stall=1, dm_memwrite=0. merge_reg <= dm_readdata with the target lane replaced by wdata[7:0] or wdata[15:0]. Next state MERGE.
  - MERGE: dm_memwrite=1, dm_writedata=merge_reg, stall=0. Next state IDLE unconditionally. Inputs are still the held instruction and are ignored for new store decisions.
- mem_read and mem_write both set: treated as a store; rdata=0.
- No request: dm_memwrite=0, stall=0, rdata=0. dm_endereco still follows addr.
- Reset:
  - State IDLE; merge_reg=0; bad_vaddr=0.
  - While reset is high, stall, dm_memwrite, misaligned and rdata are forced to 0.
  - Reset asserted in MERGE aborts the RMW; no write reaches memory.

## Timing
- Load: combinational, result valid in the request cycle.
- Word store: memory updated at the first rising edge.
- Sub-word store:
  - 2 cycles;
  - stall high only in cycle 1;
  - memory updated at the edge ending cycle 2.
- A load or store in the cycle after any write sees the updated word; no forwarding is needed.
- Back-to-back sub-word stores to the same word: the second RMW reads the first's result.
- Outputs other than bad_vaddr and the internal state are combinational from inputs and state.

## Test plan
- Reset, then SW addr 0x10, wdata 0xDEADBEEF -> dm_memwrite=1 and dm_endereco=0x4 in the same cycle, stall=0. Next-cycle LW 0x10 -> rdata 0xDEADBEEF.
- SB addr 0x11, wdata 0x000000AA:
  - cycle 1: stall=1, dm_memwrite=0;
  - cycle 2: dm_memwrite=1, dm_writedata 0xDEADAAEF;
  - then LB 0x11 -> 0xFFFFFFAA, LBU 0x11 -> 0x000000AA.
- SH addr 0x12, wdata 0x00001234 -> written word 0x1234AAEF. Then LH 0x12 -> 0x00001234, LH 0x10 -> 0xFFFFAAEF, LHU 0x10 -> 0x0000AAEF.
- LW addr 0x13 -> misaligned=1, rdata=0, bad_vaddr=0x13 after the edge. SH addr 0x13 -> misaligned=1, no dm_memwrite, no stall.
- SB addr 0x10, wdata 0x55, with reset asserted during the MERGE cycle -> no dm_memwrite pulse, state IDLE, word at index 0x4 unchanged (0x1234AAEF), all outputs 0.
- SB 0x20 (0x11) immediately followed by SB 0x21 (0x22) on a zeroed word -> two 2-cycle RMWs, final word 0x00002211.
